nioshello_onchip_mem_loader: RTL
================================

NIOSHELLO_ONCHIP_MEM_LOADER -- requirements
Module: nioshello_onchip_mem_loader

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 15, word-address width of the memory port; DEPTH, default 30720, number of 32-bit words; BASE_ADDR, default 0, first word written per packet.
REQ-002 clk  in  1  sole clock; all logic SHALL be rising-edge clk.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 snk_data  in  8  Avalon-ST byte.
REQ-005 snk_valid  in  1  byte valid.
REQ-006 snk_sop  in  1  first byte of packet.
REQ-007 snk_eop  in  1  last byte of packet.
REQ-008 snk_ready  out  1  byte accepted on clk edge when snk_valid & snk_ready.
REQ-009 mem_address  out  ADDR_W  word address to on-chip memory.
REQ-010 mem_byteenable  out  4  lane enables; bit n = bits 8n+7:8n.
REQ-011 mem_chipselect, mem_write  out  1 each  write strobe pair; always equal.
REQ-012 mem_writedata  out  32  packed word.
REQ-013 mem_clken  out  1  memory clock enable.
REQ-014 busy  out  1  packet in progress.
REQ-015 done  out  1  one-cycle pulse at packet end.
REQ-016 overflow  out  1  sticky; packet exceeded DEPTH.
REQ-017 word_count  out  16  words written in current/last packet.

Function
REQ-018 The FSM SHALL have states IDLE, PACK, DONE; all outputs SHALL be registered.
REQ-019 IDLE: snk_ready=1; bytes without snk_sop SHALL be consumed and discarded; a byte with snk_sop SHALL go to PACK, set busy=1, set lane=0, set next address=BASE_ADDR, clear word_count and overflow, and be stored in lane 0.
REQ-020 Packing SHALL be little-endian: the k-th accepted byte of a word SHALL go to lane k (k=0..3).
REQ-021 Word complete (4th lane filled, or snk_eop byte accepted): on the next cycle, mem_write=mem_chipselect=1 for exactly one cycle, with mem_address=next address, mem_writedata=packed word, and mem_byteenable=filled lanes (eop after 2 bytes -> 4'b0011).
REQ-022 Unfilled lanes of mem_writedata SHALL be 0.
REQ-023 After each issued write, address SHALL increment by 1, word_count SHALL increment by 1, and lane SHALL return to 0.
REQ-024 snk_ready SHALL stay 1 in PACK; a byte arriving during a write cycle SHALL be accepted (a separate holding register is required), so throughput is 1 byte/cycle.
REQ-025 snk_sop together with snk_eop SHALL form a one-byte packet: one write, byteenable 4'b0001.
REQ-026 snk_sop in PACK without snk_eop SHALL restart: the partial word is discarded with no write, address returns to BASE_ADDR, word_count and overflow clear, and the byte goes to lane 0.
REQ-027 Overflow: when a word completes and address > BASE_ADDR+DEPTH-1, the write SHALL be suppressed, overflow SHALL be set, and word_count SHALL not increment; remaining bytes SHALL be consumed until snk_eop.
REQ-028 Address arithmetic SHALL be ADDR_W+1 bits wide so that the overflow compare never wraps.
REQ-029 Accepting snk_eop SHALL lead to DONE on the cycle of the final write (or the suppressed write); DONE SHALL hold snk_ready=0 and done=1 for one cycle, then return to IDLE with busy=0.
REQ-030 word_count and overflow SHALL hold their values until the next snk_sop.
REQ-031 mem_clken SHALL be 1 whenever reset_n is high.
REQ-032 The block SHALL never issue reads; mem_write=0 implies mem_chipselect=0.

Reset
REQ-033 While reset_n=0, all outputs SHALL be 0 (including snk_ready and mem_clken), the state SHALL be IDLE, and lane and address SHALL be cleared; reset asserted mid-packet SHALL abort it with no partial write.
REQ-034 snk_ready and mem_clken SHALL rise on the first clk edge after reset_n deasserts.

Verification
REQ-035 8 bytes 0x11..0x88, sop on first, eop on last, continuous valid -> writes addr 0 data 0x44332211 be 0xF, then addr 1 data 0x88776655 be 0xF; word_count=2; one done pulse.
REQ-036 6-byte packet -> second write has be 0x3, data 0x00006655; word_count=2.
REQ-037 Single byte 0xA5 with sop and eop -> one write, addr 0, data 0x000000A5, be 0x1; done the following cycle.
REQ-038 DEPTH=4, 20-byte packet -> writes to addr 0..3 only; overflow=1; word_count=4; all 20 bytes accepted.
REQ-039 sop, 3 bytes, then new sop plus 4 bytes with eop -> no write from the first packet; one write at addr 0 with the new data.
REQ-040 reset_n pulsed low after 2 bytes -> no write; all outputs 0; a clean packet afterwards starts at addr 0.

Source files
------------

// File: rtl/nioshello_onchip_mem_loader.sv
// ---------------------------------------------------------------------------
// nioshello_onchip_mem_loader
//
// Receives an Avalon-ST byte stream and packs it little-endian into 32-bit
// words. Each word is written into an on-chip memory, starting at BASE_ADDR
// for every packet.
//
// Ports
//   clk, reset_n         : rising-edge clock, asynchronous active-low reset
//   snk_data/valid/sop/eop/ready : Avalon-ST byte sink
//   mem_address          : word address (ADDR_W bits)
//   mem_byteenable       : filled lanes of the word being written
//   mem_chipselect/write : write strobe pair (always equal; no reads issued)
//   mem_writedata        : packed word, unfilled lanes zero
//   mem_clken            : memory clock enable, high out of reset
//   busy                 : packet in progress
//   done                 : one-cycle pulse at packet end
//   overflow             : sticky until next sop; packet exceeded DEPTH words
//   word_count           : words written in current/last packet
// ---------------------------------------------------------------------------
module nioshello_onchip_mem_loader #(
  parameter int ADDR_W    = 15,
  parameter int DEPTH     = 30720,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       word_count
);

  // Address arithmetic carries one extra bit so the overflow compare never wraps.
  localparam int                BASE_I    = BASE_ADDR;
  localparam int                LAST_I    = BASE_ADDR + DEPTH - 1;
  localparam logic [ADDR_W:0]   BASE_W    = BASE_I[ADDR_W:0];
  localparam logic [ADDR_W:0]   LAST_ADDR = LAST_I[ADDR_W:0];
  localparam logic [ADDR_W:0]   ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PACK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Lane index of the byte just accepted -> enables for lanes 0..lane.
  function automatic logic [3:0] lanes_to_be(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      2'd3:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_lane;
  logic [31:0]       r_buf;
  logic [ADDR_W:0]   r_addr;
  logic              r_snk_ready;
  logic [ADDR_W-1:0] r_mem_address;
  logic [3:0]        r_mem_be;
  logic              r_mem_wr;
  logic [31:0]       r_mem_wdata;
  logic              r_clken;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic [15:0]       r_word_count;

  logic [1:0]        w_lane_nxt;
  logic [31:0]       w_buf_nxt;
  logic [ADDR_W:0]   w_addr_nxt;
  logic              w_ready_nxt;
  logic [ADDR_W-1:0] w_maddr_nxt;
  logic [3:0]        w_be_nxt;
  logic              w_wr_nxt;
  logic [31:0]       w_wdata_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_ovf_nxt;
  logic [15:0]       w_wc_nxt;

  logic              w_accept;
  logic              w_take;
  logic              w_start;
  logic [1:0]        w_lane_base;
  logic [31:0]       w_buf_base;
  logic [ADDR_W:0]   w_addr_base;
  logic [15:0]       w_wc_base;
  logic              w_ovf_base;
  logic [31:0]       w_merged;
  logic              w_complete;

  assign w_accept = snk_valid & r_snk_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_buf_nxt   = r_buf;
    w_addr_nxt  = r_addr;
    w_ready_nxt = 1'b1;
    w_maddr_nxt = r_mem_address;
    w_be_nxt    = r_mem_be;
    w_wr_nxt    = 1'b0;
    w_wdata_nxt = r_mem_wdata;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_overflow;
    w_wc_nxt    = r_word_count;
    w_take      = 1'b0;
    w_start     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        // Bytes without sop are consumed and dropped.
        if (w_accept && snk_sop) begin
          w_take  = 1'b1;
          w_start = 1'b1;
        end else begin
          w_take  = 1'b0;
        end
      end
      S_PACK: begin
        if (w_accept) begin
          w_take  = 1'b1;
          w_start = snk_sop;  // sop mid-packet restarts, partial word dropped
        end else begin
          w_take  = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Packet context the incoming byte is merged into (fresh on sop).
    w_lane_base = w_start ? 2'd0 : r_lane;
    w_buf_base  = w_start ? 32'd0 : r_buf;
    w_addr_base = w_start ? BASE_W : r_addr;
    w_wc_base   = w_start ? 16'd0 : r_word_count;
    w_ovf_base  = w_start ? 1'b0 : r_overflow;
    w_merged    = w_buf_base | ({24'd0, snk_data} << {w_lane_base, 3'b000});
    w_complete  = (w_lane_base == 2'd3) || snk_eop;

    if (w_take) begin
      w_busy_nxt  = 1'b1;
      w_state_nxt = snk_eop ? S_DONE : S_PACK;
      w_ready_nxt = ~snk_eop;
      w_done_nxt  = snk_eop;
      w_addr_nxt  = w_addr_base;
      w_wc_nxt    = w_wc_base;
      w_ovf_nxt   = w_ovf_base;
      if (w_complete) begin
        // The output registers hold the word, so the pack buffer is free
        // for the next byte immediately.
        w_lane_nxt = 2'd0;
        w_buf_nxt  = 32'd0;
        if (w_addr_base > LAST_ADDR) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_wr_nxt    = 1'b1;
          w_maddr_nxt = w_addr_base[ADDR_W-1:0];
          w_wdata_nxt = w_merged;
          w_be_nxt    = lanes_to_be(w_lane_base);
          w_addr_nxt  = w_addr_base + ADDR_ONE;
          w_wc_nxt    = w_wc_base + 16'd1;
        end
      end else begin
        w_lane_nxt = w_lane_base + 2'd1;
        w_buf_nxt  = w_merged;
      end
    end else begin
      w_lane_nxt = w_lane_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane        <= 2'd0;
      r_buf         <= 32'd0;
      r_addr        <= '0;
      r_snk_ready   <= 1'b0;
      r_mem_address <= '0;
      r_mem_be      <= 4'd0;
      r_mem_wr      <= 1'b0;
      r_mem_wdata   <= 32'd0;
      r_clken       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_word_count  <= 16'd0;
    end else begin
      r_lane        <= w_lane_nxt;
      r_buf         <= w_buf_nxt;
      r_addr        <= w_addr_nxt;
      r_snk_ready   <= w_ready_nxt;
      r_mem_address <= w_maddr_nxt;
      r_mem_be      <= w_be_nxt;
      r_mem_wr      <= w_wr_nxt;
      r_mem_wdata   <= w_wdata_nxt;
      r_clken       <= 1'b1;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_overflow    <= w_ovf_nxt;
      r_word_count  <= w_wc_nxt;
    end
  end

  assign snk_ready      = r_snk_ready;
  assign mem_address    = r_mem_address;
  assign mem_byteenable = r_mem_be;
  assign mem_chipselect = r_mem_wr;
  assign mem_write      = r_mem_wr;
  assign mem_writedata  = r_mem_wdata;
  assign mem_clken      = r_clken;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign word_count     = r_word_count;

endmodule
